// File: rtl/riscv_arb_pkg.sv
// Shared definitions for the unified memory arbiter.
//   arb_state_t : arbiter FSM state encodings
//   SZ_B/H/W    : memory access size codes
//   tmo_width   : width of the timeout counter for a given timeout
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DROP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Counter must hold values 0 .. cyc-1; a zero timeout still gets one bit.
    function automatic int unsigned tmo_width(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// 32-bit free-running event counter, wraps at 2^32.
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear
//   en    : count this cycle
//   count : current count
module arb_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port variable-latency memory between the fetch port and
// the data port. Each access runs request -> grant -> ack; data has priority.
// A flush cancels a pending or in-flight fetch (in-flight ones drain in DROP).
// Optional feature macro: ARB_PERF_CNT_EN adds stall/conflict counters.
// Ports:
//   clk, reset(async, active-low)
//   if_req/if_addr -> if_rdata/if_ready            fetch port
//   dm_req/dm_we/dm_size/dm_addr/dm_wdata -> dm_rdata/dm_ready   data port
//   flush                                          cancel fetch
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata, mem_rdata/mem_ack   memory
//   stall                                          pipeline hold
//   perf_stall_cnt, perf_conflict_cnt              (ARB_PERF_CNT_EN only)
//   err                                            timeout abort pulse
module unified_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [1:0]    dm_size,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    input  logic          flush,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_conflict_cnt,
`endif
    output logic          err
);

    localparam int unsigned     CW       = tmo_width(TIMEOUT_CYC);
    localparam logic [CW-1:0]   TMO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
    localparam bit              TMO_EN   = (TIMEOUT_CYC > 0);

    arb_state_t    state;
    logic [CW-1:0] tmo_cnt;
    logic          grant_dm;
    logic          grant_if;
    logic          tmo_hit;

    // A requester whose ready is pulsing this cycle is still holding req;
    // masking it prevents a duplicate grant in that IDLE cycle.
    assign grant_dm = dm_req & ~dm_ready;
    assign grant_if = if_req & ~if_ready & ~flush;
    assign tmo_hit  = TMO_EN && !mem_ack && (tmo_cnt == TMO_LAST);

    assign stall = reset & ((if_req & ~if_ready) | (dm_req & ~dm_ready));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_rdata  <= '0;
            dm_ready  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_dm) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_size  <= dm_size;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= DATA;
                    end else if (grant_if) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_size  <= SZ_W;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= FETCH;
                    end
                end
                default: begin
                    // FETCH, DATA and DROP share completion and timeout handling;
                    // only the owner decides where data and ready go.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                        if (state == DATA) begin
                            dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end else if (state == FETCH && !flush) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                        err     <= 1'b1;
                        if (state == DATA) begin
                            dm_rdata <= '0;
                            dm_ready <= 1'b1;
                        end else if (state == FETCH && !flush) begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == FETCH && flush) begin
                            state <= DROP;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic conflict;
    assign conflict = (state == IDLE) & if_req & dm_req;

    arb_perf_counter u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall),
        .count (perf_stall_cnt)
    );

    arb_perf_counter u_conflict_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (conflict),
        .count (perf_conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a variable-latency memory
// responder and a scoreboard of expected ready pulses (port + data).
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_conflict_cnt;
`endif

    unified_mem_arbiter #(
        .AW          (32),
        .DW          (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_size   (dm_size),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
`ifdef ARB_PERF_CNT_EN
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_conflict_cnt (perf_conflict_cnt),
`endif
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        bit          is_dm;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // Memory contents: fixed instruction at 0x40, address-derived elsewhere.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    always_comb mem_rdata = rd(mem_addr);

    // Memory responder: ack on the mem_lat-th consecutive mem_req cycle.
    int mem_lat = 1;
    bit ack_en  = 1'b1;
    int busy    = 0;
    initial mem_ack = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!mem_req || mem_ack) begin
            mem_ack = 1'b0;
            busy    = 0;
        end else begin
            busy = busy + 1;
            if (ack_en && busy == mem_lat) mem_ack = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input bit is_dm, input logic [31:0] data);
        exp_t e;
        vecs++;
        assert (sb.size() != 0) else begin
            errs++;
            $error("FAIL sb_unexpected: observed ready port=%0d data=%h expected no ready", is_dm, data);
            return;
        end
        e = sb.pop_front();
        assert (e.is_dm === is_dm && e.data === data) else begin
            errs++;
            $error("FAIL sb_ready: observed port=%0d data=%h expected port=%0d data=%h",
                   is_dm, data, e.is_dm, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (if_ready) sb_check(1'b0, if_rdata);
            if (dm_ready) sb_check(1'b1, dm_rdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Waits up to maxc negedges for the chosen ready; stops on the ready cycle.
    task automatic wait_rdy(input bit is_dm, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            mid();
            if (is_dm ? dm_ready : if_ready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    bit ok;

    initial begin
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_size  = 2'b10;
        dm_addr  = '0;
        dm_wdata = '0;
        flush    = 1'b0;
        #1 reset = 1'b0;
        if_req   = 1'b1;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_stall_held", stall, 1'b0);
        check("rst_readies", {if_ready, dm_ready, err}, 3'b000);
        check("rst_mem_addr", mem_addr, 32'h0);
        if_req = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();

        // 1. fetch with two-cycle memory
        cyc();
        mem_lat = 2;
        if_req  = 1'b1;
        if_addr = 32'h40;
        sb.push_back('{1'b0, 32'h0050_0093});
        mid();
        check("t1_c1_stall", stall, 1'b1);
        check("t1_c1_mem_req", mem_req, 1'b0);
        cyc(); mid();
        check("t1_c2_mem_req", mem_req, 1'b1);
        check("t1_c2_mem_addr", mem_addr, 32'h40);
        check("t1_c2_we_size", {mem_we, mem_size}, 3'b010);
        check("t1_c2_stall", stall, 1'b1);
        cyc(); mid();
        check("t1_c3_ready", if_ready, 1'b0);
        check("t1_c3_stall", stall, 1'b1);
        cyc(); mid();
        check("t1_c4_if_ready", if_ready, 1'b1);
        check("t1_c4_if_rdata", if_rdata, 32'h0050_0093);
        check("t1_c4_stall", stall, 1'b0);
        cyc();
        if_req = 1'b0;
        mid();
        check("t1_c5_no_regrant", {mem_req, if_ready}, 2'b00);

        // 2. simultaneous fetch and load: data first
        cyc();
        mem_lat = 1;
        if_req  = 1'b1;
        if_addr = 32'h44;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_size = 2'b10;
        dm_addr = 32'h100;
        sb.push_back('{1'b1, rd(32'h100)});
        sb.push_back('{1'b0, rd(32'h44)});
        mid();
        check("t2_stall", stall, 1'b1);
        cyc(); mid();
        check("t2_data_first", mem_addr, 32'h100);
        wait_rdy(1'b1, 10, ok);
        check("t2_dm_ready_seen", ok, 1'b1);
        check("t2_idle_gap", mem_req, 1'b0);
        cyc();
        dm_req = 1'b0;
        mid();
        check("t2_fetch_issue", {mem_req, mem_addr}, {1'b1, 32'h44});
        check("t2_fetch_size", mem_size, 2'b10);
        wait_rdy(1'b0, 10, ok);
        check("t2_if_ready_seen", ok, 1'b1);
        cyc();
        if_req = 1'b0;

        // 3. byte store, zero-wait memory
        cyc();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_size  = 2'b00;
        dm_addr  = 32'h203;
        dm_wdata = 32'hAB;
        sb.push_back('{1'b1, rd(32'h203)});
        mid();
        cyc(); mid();
        check("t3_mem_we_size", {mem_req, mem_we, mem_size}, 4'b1100);
        check("t3_mem_addr", mem_addr, 32'h203);
        check("t3_mem_wdata", mem_wdata, 32'hAB);
        cyc(); mid();
        check("t3_dm_ready_c3", dm_ready, 1'b1);
        cyc();
        dm_req = 1'b0;
        dm_we  = 1'b0;

        // 4. flush mid-fetch, ack three cycles later
        cyc();
        mem_lat = 4;
        if_req  = 1'b1;
        if_addr = 32'h60;
        mid();
        cyc();
        flush  = 1'b1;
        if_req = 1'b0;
        mid();
        check("t4_fetch_out", {mem_req, mem_addr}, {1'b1, 32'h60});
        cyc();
        flush   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h80;
        sb.push_back('{1'b0, rd(32'h80)});
        mid();
        check("t4_drop_holds", {mem_req, mem_addr}, {1'b1, 32'h60});
        cyc(); mid();
        cyc(); mid();
        check("t4_late_ack", mem_ack, 1'b1);
        cyc();
        mem_lat = 1;
        mid();
        check("t4_no_if_ready", {if_ready, mem_req}, 2'b00);
        cyc(); mid();
        check("t4_next_fetch", {mem_req, mem_addr}, {1'b1, 32'h80});
        wait_rdy(1'b0, 10, ok);
        check("t4_next_ready_seen", ok, 1'b1);
        cyc();
        if_req = 1'b0;

        // 4b. flush coincident with ack, then flush blocking grant in IDLE
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h90;
        mid();
        cyc();
        flush = 1'b1;
        mid();
        check("t4b_ack", mem_ack, 1'b1);
        cyc(); mid();
        check("t4b_suppressed", {if_ready, mem_req}, 2'b00);
        check("t4b_stall", stall, 1'b1);
        cyc(); mid();
        check("t4b_flush_blocks", mem_req, 1'b0);
        cyc();
        flush  = 1'b0;
        if_req = 1'b0;

        // 5. timeout after 8 busy cycles
        cyc();
        ack_en  = 1'b0;
        dm_req  = 1'b1;
        dm_size = 2'b10;
        dm_addr = 32'h300;
        sb.push_back('{1'b1, 32'h0});
        mid();
        for (int i = 0; i < 8; i++) begin
            cyc(); mid();
            check("t5_busy", {mem_req, err, dm_ready}, 3'b100);
        end
        cyc(); mid();
        check("t5_err", {err, dm_ready, mem_req}, 3'b110);
        check("t5_rdata_zero", dm_rdata, 32'h0);
        cyc();
        dm_req = 1'b0;
        ack_en = 1'b1;
        mid();
        check("t5_err_pulse", {err, mem_req}, 2'b00);

        // 6. reset mid-DATA
        cyc();
        ack_en  = 1'b0;
        dm_req  = 1'b1;
        dm_addr = 32'h400;
        mid();
        cyc(); mid();
        check("t6_in_data", mem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t6_mem_req_async", mem_req, 1'b0);
        check("t6_stall", stall, 1'b0);
        check("t6_outputs", {if_ready, dm_ready, err, mem_we, mem_size}, 6'b0);
        check("t6_if_rdata", if_rdata, 32'h0);
        check("t6_mem_addr", mem_addr, 32'h0);
`ifdef ARB_PERF_CNT_EN
        check("t6_perf_stall", perf_stall_cnt, 32'h0);
        check("t6_perf_conflict", perf_conflict_cnt, 32'h0);
`endif
        dm_req = 1'b0;
        cyc();
        cyc();
        reset  = 1'b1;
        ack_en = 1'b1;

        // recovery fetch after reset
        cyc();
        mem_lat = 1;
        if_req  = 1'b1;
        if_addr = 32'h40;
        sb.push_back('{1'b0, 32'h0050_0093});
        wait_rdy(1'b0, 10, ok);
        check("t7_recover_seen", ok, 1'b1);
        cyc();
        if_req = 1'b0;
        cyc();
        cyc();
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
